// File: rtl/ycbcr444to422.sv
// 4:4:4 -> 4:2:2 chroma decimator: pairs of pixels become two beats (Y0/Cb, Y1/Cr)
// with averaged chroma; a lone end-of-line pixel is emitted without averaging.
module ycbcr444to422 #(
  parameter int DSIZE = 8,
  parameter int ROUND = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] inY,
  input  logic [DSIZE-1:0] inCb,
  input  logic [DSIZE-1:0] inCr,
  input  logic             in_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] outY,
  output logic [DSIZE-1:0] outC,
  output logic             out_eol
);

  typedef enum logic [1:0] {ACC0, ACC1, EMIT0, EMIT1} state_e;

  typedef struct packed {
    logic [DSIZE-1:0] y;
    logic [DSIZE-1:0] cb;
    logic [DSIZE-1:0] cr;
  } pix_t;

  typedef struct packed {
    logic [DSIZE-1:0] y;
    logic [DSIZE-1:0] c;
    logic             eol;
  } beat_t;

  localparam logic [DSIZE:0] RND = {{DSIZE{1'b0}}, (ROUND != 0)};

  // One extra bit of headroom so 2*max + 1 cannot wrap.
  function automatic logic [DSIZE-1:0] cavg(input logic [DSIZE-1:0] a,
                                            input logic [DSIZE-1:0] b);
    logic [DSIZE:0] s;
    s = {1'b0, a} + {1'b0, b} + RND;
    return s[DSIZE:1];
  endfunction

  state_e state_q, state_d;
  logic   odd_q, odd_d;
  pix_t   p0_q, p0_d;
  beat_t  beat_q, beat_d;
  beat_t  nxt_q, nxt_d;
  logic   in_xfer, out_xfer;

  assign in_ready  = rst_n & ((state_q == ACC0) | (state_q == ACC1));
  assign out_valid = (state_q == EMIT0) | (state_q == EMIT1);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign outY    = beat_q.y;
  assign outC    = beat_q.c;
  assign out_eol = beat_q.eol;

  always_comb begin
    state_d = state_q;
    odd_d   = odd_q;
    p0_d    = p0_q;
    beat_d  = beat_q;
    nxt_d   = nxt_q;
    case (state_q)
      ACC0: if (in_xfer) begin
        p0_d = '{y: inY, cb: inCb, cr: inCr};
        if (in_eol) begin
          beat_d  = '{y: inY, c: inCb, eol: 1'b0};
          odd_d   = 1'b1;
          state_d = EMIT0;
        end else begin
          state_d = ACC1;
        end
      end
      ACC1: if (in_xfer) begin
        // Beat 0 goes straight to the output register; beat 1 is staged.
        beat_d  = '{y: p0_q.y, c: cavg(p0_q.cb, inCb), eol: 1'b0};
        nxt_d   = '{y: inY, c: cavg(p0_q.cr, inCr), eol: in_eol};
        state_d = EMIT0;
      end
      EMIT0: if (out_xfer) begin
        beat_d  = odd_q ? '{y: p0_q.y, c: p0_q.cr, eol: 1'b1} : nxt_q;
        state_d = EMIT1;
      end
      EMIT1: if (out_xfer) begin
        odd_d   = 1'b0;
        state_d = ACC0;
      end
      default: state_d = ACC0;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC0;
      odd_q   <= 1'b0;
      p0_q    <= '0;
      beat_q  <= '0;
      nxt_q   <= '0;
    end else begin
      state_q <= state_d;
      odd_q   <= odd_d;
      p0_q    <= p0_d;
      beat_q  <= beat_d;
      nxt_q   <= nxt_d;
    end
  end

endmodule

// File: tb/tb_ycbcr444to422.sv
// Bench for ycbcr444to422: vector table + scoreboard, ROUND=1 and ROUND=0 side by side.
module tb_ycbcr444to422;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_eol = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] inY = '0, inCb = '0, inCr = '0;
  logic       in_ready, out_valid, out_eol;
  logic [7:0] outY, outC;
  logic       in_ready0, out_valid0, out_eol0;
  logic [7:0] outY0, outC0;

  always #5 clock = ~clock;

  ycbcr444to422 #(.DSIZE(8), .ROUND(1)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inY(inY), .inCb(inCb), .inCr(inCr), .in_eol(in_eol),
    .out_valid(out_valid), .out_ready(out_ready),
    .outY(outY), .outC(outC), .out_eol(out_eol));

  ycbcr444to422 #(.DSIZE(8), .ROUND(0)) dut0 (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .inY(inY), .inCb(inCb), .inCr(inCr), .in_eol(in_eol),
    .out_valid(out_valid0), .out_ready(out_ready),
    .outY(outY0), .outC(outC0), .out_eol(out_eol0));

  typedef struct {
    int y0, cb0, cr0, y1, cb1, cr1;
    int odd, eol1;
    int b0c1, b0c0, b1c1, b1c0;
  } vec_t;

  typedef struct {
    int y, c1, c0, eol;
  } beat_t;

  beat_t sb[$];
  beat_t mb;
  vec_t  vt[5];
  vec_t  rv;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every accepted output beat must match the queue head.
  always @(negedge clock) begin
    if (rst_n) begin
      chk("r0_valid_align", int'(out_valid0), int'(out_valid));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mb = sb.pop_front();
          chk("beat_y",    int'(outY),    mb.y);
          chk("beat_c",    int'(outC),    mb.c1);
          chk("beat_eol",  int'(out_eol), mb.eol);
          chk("beat_y_r0", int'(outY0),   mb.y);
          chk("beat_c_r0", int'(outC0),   mb.c0);
          chk("beat_eol_r0", int'(out_eol0), mb.eol);
        end
      end
    end
  end

  task automatic send(input int y, input int cb, input int cr, input bit eol);
    int n;
    n = 0;
    inY = 8'(y); inCb = 8'(cb); inCr = 8'(cr); in_eol = eol;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic do_vec(input vec_t v);
    beat_t b;
    b = '{v.y0, v.b0c1, v.b0c0, 0};
    sb.push_back(b);
    b = '{(v.odd != 0) ? v.y0 : v.y1, v.b1c1, v.b1c0, (v.odd != 0) ? 1 : v.eol1};
    sb.push_back(b);
    send(v.y0, v.cb0, v.cr0, v.odd != 0);
    if (v.odd == 0) send(v.y1, v.cb1, v.cr1, v.eol1 != 0);
    chk("latency_valid", int'(out_valid), 1);
    chk("latency_y",     int'(outY),      v.y0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic int mavg(input int a, input int b, input int r);
    return (a + b + r) / 2;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{50, 100, 200, 60, 103, 51, 0, 1, 102, 101, 126, 125};
    vt[1] = '{10, 255, 0, 20, 255, 255, 0, 0, 255, 255, 128, 127};
    vt[2] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    vt[3] = '{70, 90, 180, 0, 0, 0, 1, 0, 90, 90, 180, 180};
    vt[4] = '{1, 3, 4, 2, 4, 7, 0, 1, 4, 3, 6, 5};

    // Reset state
    #1;
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_outY",      int'(outY),      0);
    chk("rst_outC",      int'(outC),      0);
    chk("rst_out_eol",   int'(out_eol),   0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", int'(in_ready), 1);

    // Table vectors, back to back with out_ready high
    for (int i = 0; i < 5; i++) do_vec(vt[i]);
    drain();
    chk("odd_back_to_acc0", int'(in_ready), 1);

    // Random pairs against a bench model
    for (int i = 0; i < 6; i++) begin
      rv.y0 = $urandom_range(0, 255); rv.cb0 = $urandom_range(0, 255); rv.cr0 = $urandom_range(0, 255);
      rv.y1 = $urandom_range(0, 255); rv.cb1 = $urandom_range(0, 255); rv.cr1 = $urandom_range(0, 255);
      rv.odd = 0; rv.eol1 = $urandom_range(0, 1);
      rv.b0c1 = mavg(rv.cb0, rv.cb1, 1); rv.b0c0 = mavg(rv.cb0, rv.cb1, 0);
      rv.b1c1 = mavg(rv.cr0, rv.cr1, 1); rv.b1c0 = mavg(rv.cr0, rv.cr1, 0);
      do_vec(rv);
    end
    drain();

    // Backpressure in EMIT0 for 5 cycles, with a pixel waiting at the input
    out_ready = 1'b0;
    do_vec(vt[0]);
    inY = 8'd99; inCb = 8'd98; inCr = 8'd97; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("bp_valid",    int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready),  0);
      chk("bp_hold_y",   int'(outY),      50);
      chk("bp_hold_c",   int'(outC),      102);
      chk("bp_hold_eol", int'(out_eol),   0);
    end
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("bp_back_to_acc0", int'(in_ready), 1);

    // Reset while in EMIT1 discards the pending beat
    out_ready = 1'b0;
    do_vec(vt[4]);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("emit1_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready",  int'(in_ready),  0);
    chk("arst_outC",      int'(outC),      0);
    chk("arst_out_eol",   int'(out_eol),   0);
    void'(sb.pop_front());
    chk("arst_one_left_discarded", sb.size(), 0);
    @(negedge clock);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    do_vec(vt[1]);
    drain();

    // Reset mid-pair (in ACC1) drops the captured P0
    send(11, 22, 33, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acc1_in_ready", int'(in_ready), 0);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    do_vec(vt[0]);
    drain();
    repeat (4) @(posedge clock);
    #1;
    chk("final_queue_empty", sb.size(), 0);
    chk("final_out_valid", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
